// File: rtl/util_tx_timestamp_gate_pkg.sv
// Shared constants for the TX timestamp gate.
// State encoding, late-policy values and head classification bundle.
package util_tx_timestamp_gate_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  localparam logic POLICY_SEND_LATE = 1'b0;
  localparam logic POLICY_DROP_LATE = 1'b1;

  typedef struct packed {
    logic late;
    logic due;
    logic early;
  } head_class_t;

  function automatic logic [1:0] end_state(
    input logic       last,
    input logic [1:0] cont
  );
    return last ? ST_IDLE : cont;
  endfunction

endpackage

// File: rtl/util_sat_counter.sv
// Saturating status counter with synchronous clear.
// Clear wins over increment; the count holds at all-ones.
module util_sat_counter
  import util_tx_timestamp_gate_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/util_tx_timestamp_gate.sv
// DAC-domain gate that releases timestamped bursts on time.
// Optional UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN drops heads too far ahead.
module util_tx_timestamp_gate
  import util_tx_timestamp_gate_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int LATE_TOLERANCE  = 0,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic                       late_policy,
  input  logic                       clear_counters,
  input  logic                       s_axis_valid,
  output logic                       s_axis_ready,
  input  logic [DATA_WIDTH-1:0]      s_axis_data,
  input  logic                       s_axis_ts_valid,
  input  logic [TIMESTAMP_WIDTH-1:0] s_axis_ts,
  input  logic                       s_axis_last,
  output logic                       m_axis_valid,
  input  logic                       m_axis_ready,
  output logic [DATA_WIDTH-1:0]      m_axis_data,
  output logic [1:0]                 state,
  output logic [COUNTER_WIDTH-1:0]   late_count,
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
  input  logic [TIMESTAMP_WIDTH-1:0] max_lead,
  output logic [COUNTER_WIDTH-1:0]   early_count,
`endif
  output logic [COUNTER_WIDTH-1:0]   underflow_count
);

  localparam int XW = TIMESTAMP_WIDTH + 1;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic                  m_valid_q;
  logic                  m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;

  logic        obuf_free;
  logic        ready;
  logic        load;
  logic        late_inc;
  logic        under_inc;
  logic        too_early;
  head_class_t hc;

  logic [XW-1:0] now_x;
  logic [XW-1:0] ts_x;
  logic [XW-1:0] ts_tol_x;

  assign now_x    = {1'b0, timestamp};
  assign ts_x     = {1'b0, s_axis_ts};
  assign ts_tol_x = ts_x + XW'(LATE_TOLERANCE);

  // classify the head against the sample clock without wrap
  always_comb begin
    hc.late  = now_x > ts_tol_x;
    hc.early = now_x < ts_x;
    hc.due   = !hc.late && !hc.early;
  end

`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
  logic          early_inc;
  logic [XW-1:0] lead_x;

  assign lead_x    = now_x + {1'b0, max_lead};
  assign too_early = (max_lead != '0) && (ts_x > lead_x);
`else
  assign too_early = 1'b0;
`endif

  assign obuf_free = !m_valid_q || m_axis_ready;

  // burst FSM: accept, forward, hold or discard the current beat
  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    load     = 1'b0;
    late_inc = 1'b0;
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
    early_inc = 1'b0;
`endif
    if (state_q == ST_WAIT) begin
      // a held head is released once due, even if now past tolerance
      if (s_axis_valid && !hc.early && obuf_free) begin
        ready   = 1'b1;
        load    = 1'b1;
        state_d = end_state(s_axis_last, ST_STREAM);
      end
    end else if (s_axis_valid && s_axis_ts_valid) begin
      if (too_early) begin
        ready   = 1'b1;
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
        early_inc = 1'b1;
`endif
        state_d = end_state(s_axis_last, ST_DROP);
      end else if (hc.late &&
                   late_policy == POLICY_DROP_LATE) begin
        ready    = 1'b1;
        late_inc = 1'b1;
        state_d  = end_state(s_axis_last, ST_DROP);
      end else if (hc.early) begin
        state_d = ST_WAIT;
      end else if (obuf_free) begin
        ready    = 1'b1;
        load     = 1'b1;
        late_inc = hc.late;
        state_d  = end_state(s_axis_last, ST_STREAM);
      end
    end else if (s_axis_valid) begin
      if (state_q == ST_DROP) begin
        ready   = 1'b1;
        state_d = end_state(s_axis_last, ST_DROP);
      end else if (obuf_free) begin
        ready   = 1'b1;
        load    = 1'b1;
        state_d = end_state(s_axis_last, ST_STREAM);
      end
    end
  end

  // output register: load a forwarded beat, else drain on ready
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = s_axis_data;
    end else if (m_axis_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // state and output registers, flushed by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign under_inc = (state_q == ST_STREAM) &&
                     !s_axis_valid && !m_valid_q;

  util_sat_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_late_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clear_counters),
    .inc  (late_inc),
    .count(late_count)
  );

  util_sat_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_under_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clear_counters),
    .inc  (under_inc),
    .count(underflow_count)
  );

`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
  util_sat_counter #(
    .WIDTH(COUNTER_WIDTH)
  ) u_early_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clear_counters),
    .inc  (early_inc),
    .count(early_count)
  );
`endif

  assign s_axis_ready = ready && !reset;
  assign m_axis_valid = m_valid_q;
  assign m_axis_data  = m_data_q;
  assign state        = state_q;

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Directed bench for util_tx_timestamp_gate.
// Covers UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN when defined.
module tb_util_tx_timestamp_gate;

  localparam int DW  = 32;
  localparam int TW  = 32;
  localparam int TOL = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] timestamp;
  logic          late_policy;
  logic          clear_counters;
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data;
  logic          s_axis_ts_valid;
  logic [TW-1:0] s_axis_ts;
  logic          s_axis_last;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [DW-1:0] m_axis_data;
  logic [1:0]    state;
  logic [CW-1:0] late_count;
  logic [CW-1:0] underflow_count;
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
  logic [TW-1:0] max_lead;
  logic [CW-1:0] early_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  util_tx_timestamp_gate #(
    .DATA_WIDTH     (DW),
    .TIMESTAMP_WIDTH(TW),
    .LATE_TOLERANCE (TOL),
    .COUNTER_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .timestamp      (timestamp),
    .late_policy    (late_policy),
    .clear_counters (clear_counters),
    .s_axis_valid   (s_axis_valid),
    .s_axis_ready   (s_axis_ready),
    .s_axis_data    (s_axis_data),
    .s_axis_ts_valid(s_axis_ts_valid),
    .s_axis_ts      (s_axis_ts),
    .s_axis_last    (s_axis_last),
    .m_axis_valid   (m_axis_valid),
    .m_axis_ready   (m_axis_ready),
    .m_axis_data    (m_axis_data),
    .state          (state),
    .late_count     (late_count),
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
    .max_lead       (max_lead),
    .early_count    (early_count),
`endif
    .underflow_count(underflow_count)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    timestamp = timestamp + 1;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(
    input logic [DW-1:0] d,
    input logic          tv,
    input logic [TW-1:0] t,
    input logic          l
  );
    s_axis_valid    = 1'b1;
    s_axis_data     = d;
    s_axis_ts_valid = tv;
    s_axis_ts       = t;
    s_axis_last     = l;
  endtask

  task automatic idle();
    s_axis_valid    = 1'b0;
    s_axis_ts_valid = 1'b0;
    s_axis_last     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    int rdy_ok;
    reset          = 1'b1;
    timestamp      = '0;
    late_policy    = 1'b0;
    clear_counters = 1'b0;
    m_axis_ready   = 1'b1;
    s_axis_data    = '0;
    s_axis_ts      = '0;
`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
    max_lead       = '0;
`endif
    idle();
    cyc();
    cyc();
    chk("rst_state", state, 0);
    chk("rst_mvalid", m_axis_valid, 0);
    chk("rst_mdata", m_axis_data, 0);
    chk("rst_sready", s_axis_ready, 0);
    chk("rst_late", late_count, 0);
    chk("rst_under", underflow_count, 0);
    reset = 1'b0;
    cyc();

    // untimed 4-beat burst
    for (int i = 0; i < 4; i++) begin
      beat(32'hA0 + i, 1'b0, '0, i == 3);
      settle();
      chk("u_ready", s_axis_ready, 1);
      cyc();
      chk("u_mvalid", m_axis_valid, 1);
      chk("u_mdata", m_axis_data, 32'hA0 + i);
    end
    idle();
    chk("u_state", state, 0);
    cyc();
    chk("u_drain", m_axis_valid, 0);
    chk("u_late", late_count, 0);
    chk("u_under", underflow_count, 0);

    // early head waits for its timestamp
    timestamp = 990;
    beat(32'hB0, 1'b1, 1000, 1'b0);
    settle();
    chk("w_ready0", s_axis_ready, 0);
    rdy_ok = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("w_state", state, 1);
      if (s_axis_ready !== (i == 9)) rdy_ok = 0;
    end
    chk("w_ready_seq", rdy_ok, 1);
    chk("w_ts", timestamp, 1000);
    cyc();
    chk("w_mvalid", m_axis_valid, 1);
    chk("w_mdata", m_axis_data, 32'hB0);
    chk("w_stream", state, 2);
    beat(32'hB1, 1'b0, '0, 1'b1);
    cyc();
    chk("w_mdata1", m_axis_data, 32'hB1);
    chk("w_idle", state, 0);
    idle();
    cyc();

    // tolerance boundary: 4 ticks past due is on time
    timestamp = 1004;
    late_policy = 1'b0;
    beat(32'hC0, 1'b1, 1000, 1'b1);
    settle();
    chk("t_ready", s_axis_ready, 1);
    cyc();
    chk("t_mvalid", m_axis_valid, 1);
    chk("t_late", late_count, 0);
    idle();
    cyc();

    // 5 ticks past due with drop policy: burst discarded
    timestamp = 1005;
    late_policy = 1'b1;
    seen = 0;
    rdy_ok = 1;
    for (int i = 0; i < 8; i++) begin
      beat(32'hD0 + i, i == 0, 1000, i == 7);
      settle();
      if (s_axis_ready !== 1'b1) rdy_ok = 0;
      cyc();
      if (m_axis_valid) seen++;
      if (i == 0) chk("d_state", state, 3);
    end
    idle();
    chk("d_ready", rdy_ok, 1);
    chk("d_seen", seen, 0);
    chk("d_idle", state, 0);
    chk("d_late", late_count, 1);
    late_policy = 1'b0;

    // backpressure holds the output register
    m_axis_ready = 1'b0;
    beat(32'hE0, 1'b0, '0, 1'b0);
    cyc();
    chk("b_mdata0", m_axis_data, 32'hE0);
    beat(32'hE1, 1'b0, '0, 1'b1);
    settle();
    chk("b_stall", s_axis_ready, 0);
    cyc();
    chk("b_hold", m_axis_data, 32'hE0);
    m_axis_ready = 1'b1;
    settle();
    chk("b_ready", s_axis_ready, 1);
    cyc();
    chk("b_mdata1", m_axis_data, 32'hE1);
    idle();
    cyc();

    // underflow counting and clear priority
    clear_counters = 1'b1;
    cyc();
    clear_counters = 1'b0;
    chk("c_late", late_count, 0);
    beat(32'hF0, 1'b0, '0, 1'b0);
    cyc();
    idle();
    for (int i = 0; i < 4; i++) cyc();
    chk("g_under", underflow_count, 3);
    clear_counters = 1'b1;
    cyc();
    clear_counters = 1'b0;
    chk("g_clr", underflow_count, 0);
    beat(32'hF1, 1'b0, '0, 1'b1);
    cyc();
    chk("g_mdata", m_axis_data, 32'hF1);
    chk("g_idle", state, 0);
    idle();
    cyc();

    // late counter saturation with single-beat late bursts
    timestamp = 3000;
    for (int i = 0; i < 5; i++) begin
      beat(32'h50 + i, 1'b1, 100, 1'b1);
      cyc();
      if (i == 1) chk("s_late2", late_count, 2);
    end
    chk("s_late_sat", late_count, 3);
    chk("s_idle", state, 0);
    late_policy = 1'b1;
    beat(32'h5F, 1'b1, 100, 1'b1);
    settle();
    chk("s_drop_rdy", s_axis_ready, 1);
    cyc();
    chk("s_drop_idle", state, 0);
    chk("s_sat_hold", late_count, 3);
    late_policy = 1'b0;
    idle();
    cyc();

    // reset mid-burst flushes the output
    beat(32'h70, 1'b0, '0, 1'b0);
    cyc();
    chk("r_stream", state, 2);
    beat(32'h71, 1'b0, '0, 1'b0);
    reset = 1'b1;
    settle();
    chk("r_sready", s_axis_ready, 0);
    cyc();
    chk("r_mvalid", m_axis_valid, 0);
    chk("r_state", state, 0);
    reset = 1'b0;
    idle();
    cyc();

`ifdef UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN
    // early limit: one tick beyond max_lead is dropped
    max_lead = 100;
    timestamp = 5000;
    beat(32'h90, 1'b1, 5101, 1'b0);
    settle();
    chk("e_ready", s_axis_ready, 1);
    cyc();
    chk("e_drop", state, 3);
    chk("e_count", early_count, 1);
    chk("e_late", late_count, 0);
    beat(32'h91, 1'b0, '0, 1'b1);
    cyc();
    chk("e_idle", state, 0);
    chk("e_nomv", m_axis_valid, 0);
    beat(32'h92, 1'b1, timestamp + 100, 1'b1);
    settle();
    chk("e_wait_rdy", s_axis_ready, 0);
    n = 0;
    while (!s_axis_ready && n < 200) begin
      cyc();
      n++;
    end
    chk("e_wait_n", n, 100);
    cyc();
    chk("e_mvalid", m_axis_valid, 1);
    chk("e_mdata", m_axis_data, 32'h92);
    chk("e_count1", early_count, 1);
    idle();
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/util_tx_timestamp_gate.md
Name: util_tx_timestamp_gate

Overview:
- Single-clock, DAC-domain timestamp gate. Sits after the DMA->DAC CDC FIFO and before util_upack2.
- Input beats arrive with timestamp sidebands (ts_valid, ts). The gate holds each timestamped beat until the free-running sample timestamp reaches it, then streams the burst.
- Generalises the earlier gate: parametrised data/timestamp width, late tolerance, selectable late policy (send-late or drop-burst), burst framing via last, and saturating late/underflow status counters.

Parameters:
- DATA_WIDTH, 64, width of s_axis_data/m_axis_data (NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH).
- TIMESTAMP_WIDTH, 64, width of timestamp and s_axis_ts.
- LATE_TOLERANCE, 0, number of ticks a beat may be past due and still count as on time.
- COUNTER_WIDTH, 16, width of the saturating status counters.

Ports:
- clk  in  1  DAC clock.
- reset  in  1  synchronous, active-high.
- timestamp  in  TIMESTAMP_WIDTH  free-running sample count; advances at most by 1 per clk.
- late_policy  in  1  0 = send late burst and count it; 1 = drop late burst and count it.
- clear_counters  in  1  synchronous clear of status counters.
- s_axis_valid  in  1  input beat valid.
- s_axis_ready  out  1  input beat accepted (accepted or discarded).
- s_axis_data  in  DATA_WIDTH  sample block.
- s_axis_ts_valid  in  1  beat starts a timed burst.
- s_axis_ts  in  TIMESTAMP_WIDTH  transmit time of this beat.
- s_axis_last  in  1  final beat of burst.
- m_axis_valid  out  1  output beat valid.
- m_axis_ready  in  1  downstream ready.
- m_axis_data  out  DATA_WIDTH  registered output data.
- state  out  2  current FSM state, for debug.
- late_count  out  COUNTER_WIDTH  saturating count of late bursts.
- underflow_count  out  COUNTER_WIDTH  saturating count of mid-burst starvation cycles.

Behaviour:
- Reset values: state=IDLE(0), m_axis_valid=0, m_axis_data=0, s_axis_ready=0, all counters=0.
- Output stage: single register. obuf_free = !m_axis_valid || m_axis_ready. An accepted, forwarded beat appears on m_axis exactly 1 cycle later. m_axis_valid drops the cycle after it is consumed unless a new beat is loaded.
- Head classification, evaluated when s_axis_valid && s_axis_ts_valid, using unsigned arithmetic and TIMESTAMP_WIDTH+1-bit sums so there is no wrap:
  - late = timestamp > s_axis_ts + LATE_TOLERANCE
  - due = !late && timestamp >= s_axis_ts
  - early = timestamp < s_axis_ts
- States: IDLE=0, WAIT=1, STREAM=2, DROP=3.
- IDLE, and STREAM on a beat with ts_valid:
  - untimed beat: forward when obuf_free. Next state is STREAM, or IDLE if last.
  - due: forward when obuf_free, then go to STREAM.
  - early: go to WAIT without accepting.
  - late with policy 0: forward, late_count+1, go to STREAM.
  - late with policy 1: discard the beat (s_axis_ready=1), late_count+1, go to DROP. If last is also set, stay IDLE.
- WAIT: s_axis_ready=0 until the head becomes due, then forward the beat and go to STREAM. If timestamp overtakes the tolerance while waiting, the beat is still forwarded and not counted as late.
- STREAM: forward beats while obuf_free. A beat with last goes to IDLE. A ts_valid beat mid-burst is re-classified as above.
- Underflow: underflow_count+1 on every cycle where state==STREAM, !s_axis_valid, and !m_axis_valid.
- DROP: s_axis_ready=1 and beats are discarded. On s_axis_last accepted, go to IDLE. A ts_valid beat arriving in DROP is classified as in IDLE that same cycle, not discarded.
- Counters saturate at all-ones. clear_counters has priority over an increment in the same cycle.
- Reset mid-burst: the output register is flushed immediately. Any partial burst is lost; upstream is responsible for restarting.

Optional Feature:
- Macro: UTIL_TX_TIMESTAMP_GATE_EARLY_LIMIT_EN.
- Defined:
  - Adds ports max_lead (in, TIMESTAMP_WIDTH) and early_count (out, COUNTER_WIDTH).
  - A head with s_axis_ts > timestamp + max_lead is "too early". It is discarded like late policy 1 (go to DROP), with early_count+1 and no late_count change.
  - max_lead = 0 disables the check.
- Undefined: no extra ports, and no beat is ever rejected as too early.

Decomposition:
- Package util_tx_timestamp_gate_pkg: state encoding constants (IDLE/WAIT/STREAM/DROP), POLICY_SEND_LATE=0, POLICY_DROP_LATE=1.
- One sub-module: util_sat_counter (parameter WIDTH; inputs clk, reset, clr, inc; output count). Instantiated 2x, or 3x with the early-limit feature.

Test Plan:
- Untimed 4-beat burst (last on beat 4), m_axis_ready=1 -> 4 outputs, each 1 cycle after acceptance; state returns to 0; counters stay 0.
- ts=1000 while timestamp=990 -> s_axis_ready=0 and state=1 for 10 cycles; first beat appears on m_axis the cycle after timestamp=1000.
- LATE_TOLERANCE=4, ts=1000 at timestamp=1004 -> forwarded, late_count=0. Same at timestamp=1005 with policy 1 -> whole 8-beat burst discarded, late_count=1, m_axis_valid never high.
- Mid-burst valid gap of 3 cycles in STREAM -> underflow_count=3. Then clear_counters pulsed together with a further underflow cycle -> count=0.
- late_count forced to saturation (COUNTER_WIDTH=2, 5 late bursts) -> holds at 3. Reset asserted mid-burst -> next cycle m_axis_valid=0, state=0.
- EARLY_LIMIT_EN with max_lead=100, ts=timestamp+101 -> burst dropped, early_count=1. With ts=timestamp+100 -> WAIT, then released normally.
